// File: rtl/fpro_timer_core_if.sv
// fpro_timer_core_if: FPro MMIO slot bus between the bridge (master) and a slot core (slave).
interface fpro_timer_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/fpro_timer_core.sv
// fpro_timer_core: 64-bit prescaled timer with compare match, auto-reload and snapshot reads.
// Define FPRO_TIMER_IRQ_EN to enable CTRL[3] and the registered match interrupt.
module fpro_timer_core #(
  parameter int PRESCALE_W = 16,
  parameter logic [PRESCALE_W-1:0] RESET_PRESCALE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  fpro_timer_core_if.slave bus,
  output logic             irq
);
  logic                  wr_en, rd_en, wr_ctrl, wr_pre, w1c, clr, tick, hit;
  logic [63:0]           count_q, count_d, cmp_q, cmp_d;
  logic [31:0]           snap_q, snap_d, rd;
  logic [PRESCALE_W-1:0] pre_q, pre_d, pcnt_q, pcnt_d;
  logic                  go_q, go_d, ar_q, ar_d, ie_q, ie_d, match_q, match_d, irq_q, irq_d;
  always_comb begin
    wr_en   = bus.cs & bus.write;
    rd_en   = bus.cs & bus.read;
    wr_ctrl = wr_en & (bus.addr == 5'd2);
    wr_pre  = wr_en & (bus.addr == 5'd3);
    w1c     = wr_en & (bus.addr == 5'd6) & bus.wr_data[0];
    clr     = wr_ctrl & bus.wr_data[1];
    // a clear swallows any tick landing on the same edge
    tick    = go_q & (pcnt_q == pre_q) & ~clr;
    hit     = tick & (count_q == cmp_q);
    pcnt_d  = (clr | wr_pre | tick) ? '0 : go_q ? pcnt_q + 1'b1 : pcnt_q;
    count_d = clr ? '0 : !tick ? count_q : (hit & ar_q) ? '0 : count_q + 64'd1;
    cmp_d   = {(wr_en & (bus.addr == 5'd5)) ? bus.wr_data : cmp_q[63:32],
               (wr_en & (bus.addr == 5'd4)) ? bus.wr_data : cmp_q[31:0]};
    pre_d   = wr_pre ? bus.wr_data[PRESCALE_W-1:0] : pre_q;
    go_d    = wr_ctrl ? bus.wr_data[0] : go_q;
    ar_d    = wr_ctrl ? bus.wr_data[2] : ar_q;
    match_d = hit | (match_q & ~w1c);
    snap_d  = (rd_en & (bus.addr == 5'd0)) ? count_q[63:32] : snap_q;
`ifdef FPRO_TIMER_IRQ_EN
    ie_d    = wr_ctrl ? bus.wr_data[3] : ie_q;
    irq_d   = match_q & ie_q;
`else
    ie_d    = 1'b0;
    irq_d   = 1'b0;
`endif
    case (bus.addr)
      5'd0:    rd = count_q[31:0];
      5'd1:    rd = snap_q;
      5'd2:    rd = {28'd0, ie_q, ar_q, 1'b0, go_q};
      5'd3:    rd = 32'(pre_q);
      5'd4:    rd = cmp_q[31:0];
      5'd5:    rd = cmp_q[63:32];
      5'd6:    rd = {31'd0, match_q};
      default: rd = '0;
    endcase
    bus.rd_data = rd_en ? rd : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      cmp_q   <= '1;
      snap_q  <= '0;
      pre_q   <= RESET_PRESCALE;
      pcnt_q  <= '0;
      go_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      snap_q  <= snap_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
      go_q    <= go_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      match_q <= match_d;
      irq_q   <= irq_d;
    end
  end
  assign irq = irq_q;
endmodule
